// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// mmio_pkg : register map, status bit positions and defaults for mmio_router
// Revision : 1.0
// ============================================================================
package mmio_pkg;

    localparam logic [1:0]  REG_DATA          = 2'd0;
    localparam logic [1:0]  REG_STATUS        = 2'd1;
    localparam logic [1:0]  REG_CMD           = 2'd2;

    localparam int          STAT_VALID_BIT    = 0;
    localparam int          STAT_OVR_BIT      = 1;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;
    localparam int          CH_STRIDE         = 4;

endpackage
`default_nettype wire

// File: rtl/mmio_channel.sv
`default_nettype none
// ============================================================================
// mmio_channel : one inbound mailbox (sticky valid/overrun) and one command reg
// Revision     : 1.0
// ============================================================================
module mmio_channel #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_data_i,
    input  logic              rd_status_i,
    input  logic              wr_cmd_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              periph_valid_i,
    input  logic [DATA_W-1:0] periph_data_i,
    output logic [DATA_W-1:0] mbox_data_o,
    output logic              mbox_valid_o,
    output logic              mbox_ovr_o,
    output logic [DATA_W-1:0] cmd_o,
    output logic              strobe_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic              strobe_q, strobe_d;

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (rd_data_i)   valid_d = 1'b0;
        if (rd_status_i) ovr_d   = 1'b0;
        // A new word only overruns if the old one was not consumed this cycle.
        if (periph_valid_i) begin
            data_d  = periph_data_i;
            valid_d = 1'b1;
            if (valid_q && !rd_data_i) ovr_d = 1'b1;
        end
        cmd_d    = wr_cmd_i ? wdata_i : cmd_q;
        strobe_d = wr_cmd_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            cmd_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            cmd_q    <= cmd_d;
            strobe_q <= strobe_d;
        end
    end

    assign mbox_data_o  = data_q;
    assign mbox_valid_o = valid_q;
    assign mbox_ovr_o   = ovr_q;
    assign cmd_o        = cmd_q;
    assign strobe_o     = strobe_q;

endmodule
`default_nettype wire

// File: rtl/mmio_router.sv
`default_nettype none
// ============================================================================
// mmio_router : dmem router between processor, RAM and NUM_CH MMIO channels
// Revision    : 1.0
// ============================================================================
module mmio_router
    import mmio_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEFAULT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     wren,
    input  logic                     rden,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [DATA_W-1:0]        ram_q,
    output logic                     ram_wren,
    output logic [DATA_W-1:0]        q_out,
    input  logic [NUM_CH-1:0]        periph_valid,
    input  logic [NUM_CH*DATA_W-1:0] periph_data,
    output logic [NUM_CH*DATA_W-1:0] cmd_out,
    output logic [NUM_CH-1:0]        cmd_strobe
);

    logic              w_hit;
    logic [ADDR_W-1:0] w_off;
    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic              w_exists;

    logic [DATA_W-1:0] w_mbox  [NUM_CH];
    logic              w_valid [NUM_CH];
    logic              w_ovr   [NUM_CH];
    logic [DATA_W-1:0] w_cmd   [NUM_CH];

    logic              sel_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign w_hit    = (addr >= MMIO_BASE);
    assign w_off    = addr - MMIO_BASE;
    assign w_ch     = w_off[5:2];
    assign w_reg    = w_off[1:0];
    assign w_exists = w_hit && (w_off < ADDR_W'(NUM_CH * CH_STRIDE));
    assign ram_wren = wren & ~w_hit;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic w_sel;
            assign w_sel = w_exists && (w_ch == 4'(c));

            mmio_channel #(
                .DATA_W (DATA_W)
            ) u_ch (
                .clock          (clock),
                .reset          (reset),
                .rd_data_i      (rden & w_sel & (w_reg == REG_DATA)),
                .rd_status_i    (rden & w_sel & (w_reg == REG_STATUS)),
                .wr_cmd_i       (wren & w_sel & (w_reg == REG_CMD)),
                .wdata_i        (data_in),
                .periph_valid_i (periph_valid[c]),
                .periph_data_i  (periph_data[c*DATA_W +: DATA_W]),
                .mbox_data_o    (w_mbox[c]),
                .mbox_valid_o   (w_valid[c]),
                .mbox_ovr_o     (w_ovr[c]),
                .cmd_o          (w_cmd[c]),
                .strobe_o       (cmd_strobe[c])
            );

            assign cmd_out[c*DATA_W +: DATA_W] = w_cmd[c];
        end
    endgenerate

    // Captured every cycle from pre-update state so loads see pre-clear values.
    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_exists && (w_ch == 4'(c))) begin
                case (w_reg)
                    REG_DATA:   rdata_d = w_mbox[c];
                    REG_STATUS: begin
                        rdata_d[STAT_VALID_BIT] = w_valid[c];
                        rdata_d[STAT_OVR_BIT]   = w_ovr[c];
                    end
                    REG_CMD:    rdata_d = w_cmd[c];
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sel_q   <= w_hit;
            rdata_q <= rdata_d;
        end
    end

    assign q_out = sel_q ? rdata_q : ram_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_router.sv
`default_nettype none
// ============================================================================
// tb_mmio_router : directed self-checking bench for mmio_router (NUM_CH = 4)
// Revision       : 1.0
// ============================================================================
module tb_mmio_router;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       addr;
    logic              wren;
    logic              rden;
    logic [DW-1:0]     data_in;
    logic [DW-1:0]     ram_q;
    logic              ram_wren;
    logic [DW-1:0]     q_out;
    logic [NCH-1:0]    periph_valid;
    logic [NCH*DW-1:0] periph_data;
    logic [NCH*DW-1:0] cmd_out;
    logic [NCH-1:0]    cmd_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_router dut (
        .clock        (clock),
        .reset        (reset),
        .addr         (addr),
        .wren         (wren),
        .rden         (rden),
        .data_in      (data_in),
        .ram_q        (ram_q),
        .ram_wren     (ram_wren),
        .q_out        (q_out),
        .periph_valid (periph_valid),
        .periph_data  (periph_data),
        .cmd_out      (cmd_out),
        .cmd_strobe   (cmd_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        check(tag, 128'(q_out), 128'(exp));
    endtask

    task automatic pulse(input int c, input logic [31:0] d);
        periph_valid[c]          = 1'b1;
        periph_data[c*DW +: DW]  = d;
        tick();
        periph_valid = '0;
    endtask

    initial begin
        reset        = 1'b1;
        addr         = '0;
        wren         = 1'b0;
        rden         = 1'b0;
        data_in      = '0;
        ram_q        = 32'h1111_1111;
        periph_valid = '0;
        periph_data  = '0;
        tick();
        tick();
        check("rst_cmd_out", cmd_out, '0);
        check("rst_strobe", 128'(cmd_strobe), '0);
        check("rst_q_out", 128'(q_out), 128'(32'h1111_1111));
        reset = 1'b0;

        // RAM region load/store
        ram_q   = 32'hDEAD_BEEF;
        addr    = 32'h10;
        wren    = 1'b1;
        rden    = 1'b1;
        data_in = 32'h99;
        #1;
        check("ram_wren_ram", 128'(ram_wren), 128'(1));
        tick();
        wren = 1'b0;
        rden = 1'b0;
        check("ram_load", 128'(q_out), 128'(32'hDEAD_BEEF));

        // ch1 mailbox basic
        pulse(1, 32'h1234_5678);
        load(32'h1005, 32'h1, "ch1_status_valid");
        load(32'h1004, 32'h1234_5678, "ch1_data");
        load(32'h1005, 32'h0, "ch1_status_clear");

        // ch0 overrun and sticky clear
        pulse(0, 32'hA);
        pulse(0, 32'hB);
        load(32'h1001, 32'h3, "ch0_status_ovr");
        load(32'h1001, 32'h1, "ch0_status_ovr_clr");
        load(32'h1000, 32'hB, "ch0_data_latest");
        load(32'h1001, 32'h0, "ch0_status_empty");

        // ch2 DATA read coincident with new word
        pulse(2, 32'h5);
        addr                     = 32'h1008;
        rden                     = 1'b1;
        periph_valid[2]          = 1'b1;
        periph_data[2*DW +: DW]  = 32'h6;
        tick();
        rden         = 1'b0;
        periph_valid = '0;
        check("ch2_coincident_old", 128'(q_out), 128'(32'h5));
        load(32'h1009, 32'h1, "ch2_status_no_ovr");
        load(32'h1008, 32'h6, "ch2_data_new");

        // ch0 STATUS read coincident with overrunning word: set wins
        pulse(0, 32'h1);
        addr                     = 32'h1001;
        rden                     = 1'b1;
        periph_valid[0]          = 1'b1;
        periph_data[0*DW +: DW]  = 32'h2;
        tick();
        rden         = 1'b0;
        periph_valid = '0;
        check("ch0_status_pre", 128'(q_out), 128'(32'h1));
        load(32'h1001, 32'h3, "ch0_status_set_wins");

        // ch3 command write
        addr    = 32'h100E;
        wren    = 1'b1;
        data_in = 32'hCAFE;
        #1;
        check("ram_wren_mmio", 128'(ram_wren), 128'(0));
        tick();
        wren = 1'b0;
        addr = 32'h0;
        check("ch3_strobe", 128'(cmd_strobe), 128'(4'b1000));
        check("ch3_cmd_out", 128'(cmd_out[3*DW +: DW]), 128'(32'hCAFE));
        tick();
        check("ch3_strobe_drop", 128'(cmd_strobe), 128'(0));
        load(32'h100E, 32'hCAFE, "ch3_cmd_readback");

        // write and read the same CMD in one cycle
        addr    = 32'h100E;
        wren    = 1'b1;
        rden    = 1'b1;
        data_in = 32'hBEEF;
        tick();
        wren = 1'b0;
        rden = 1'b0;
        check("ch3_rw_pre", 128'(q_out), 128'(32'hCAFE));
        load(32'h100E, 32'hBEEF, "ch3_rw_post");

        // ignored writes: non-existent channel, reserved reg, RO DATA
        addr    = 32'h1020;
        wren    = 1'b1;
        data_in = 32'h77;
        #1;
        check("ram_wren_nonexist", 128'(ram_wren), 128'(0));
        tick();
        addr = 32'h1003;
        tick();
        addr = 32'h1004;
        tick();
        wren = 1'b0;
        check("ignored_strobe", 128'(cmd_strobe), 128'(0));
        check("ignored_cmd_out", cmd_out,
              {32'hBEEF, 32'h0, 32'h0, 32'h0});
        load(32'h1020, 32'h0, "nonexist_read");
        load(32'h1003, 32'h0, "reserved_read");

        // back-to-back strobes, then reset mid-burst
        wren    = 1'b1;
        addr    = 32'h1002;
        data_in = 32'h1;
        tick();
        addr    = 32'h1006;
        data_in = 32'h2;
        check("b2b_strobe0", 128'(cmd_strobe), 128'(4'b0001));
        tick();
        addr    = 32'h100A;
        data_in = 32'h3;
        check("b2b_strobe1", 128'(cmd_strobe), 128'(4'b0010));
        tick();
        check("b2b_strobe2", 128'(cmd_strobe), 128'(4'b0100));
        addr                     = 32'h100E;
        data_in                  = 32'h4;
        reset                    = 1'b1;
        periph_valid             = '1;
        periph_data[1*DW +: DW]  = 32'h55;
        ram_q                    = 32'h2222_2222;
        tick();
        wren         = 1'b0;
        periph_valid = '0;
        check("rst_mid_strobe", 128'(cmd_strobe), 128'(0));
        check("rst_mid_cmd", cmd_out, '0);
        check("rst_mid_q_out", 128'(q_out), 128'(32'h2222_2222));
        reset = 1'b0;
        load(32'h1005, 32'h0, "rst_mid_status");
        load(32'h1004, 32'h0, "rst_mid_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_router.md
Name: mmio_router

Overview:
- Generalised data-memory router between processor dmem port, RAM and NUM_CH memory-mapped peripheral channels.
- Each channel has:
  - a 32-bit inbound mailbox with sticky valid/overrun flags;
  - an outbound command register with a one-cycle strobe.
- Read data is registered so MMIO loads have the same 1-cycle latency as the synchronous RAM.
- Replaces the single-sensor address mux in the top-level wrapper.

Parameters:
- NUM_CH, 4, number of peripheral channels (1..16).
- DATA_W, 32, data width.
- ADDR_W, 32, processor address width.
- MMIO_BASE, 32'h0000_1000, first MMIO word address; addresses >= MMIO_BASE are MMIO, below are RAM.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_W  processor dmem word address.
- wren  in  1  processor store strobe.
- rden  in  1  processor load strobe (MEM-stage load decode); qualifies read side effects.
- data_in  in  DATA_W  store data.
- ram_q  in  DATA_W  RAM dataOut (valid 1 cycle after addr).
- ram_wren  out  1  wren gated to RAM region.
- q_out  out  DATA_W  read data to processor (q_dmem).
- periph_valid  in  NUM_CH  per-channel one-cycle data-valid pulse.
- periph_data  in  NUM_CH*DATA_W  per-channel data; channel c at [c*DATA_W +: DATA_W].
- cmd_out  out  NUM_CH*DATA_W  per-channel command register, same packing.
- cmd_strobe  out  NUM_CH  one-cycle pulse when CPU writes CMD.

Behaviour:
Address decode (combinational):
- hit = addr >= MMIO_BASE; off = addr - MMIO_BASE.
- ch = off[5:2]; reg = off[1:0]. Channel exists if ch < NUM_CH and off < 64.
- Register map: reg 0 DATA (RO), reg 1 STATUS (RO; bit0 valid, bit1 overrun, others 0), reg 2 CMD (RW), reg 3 reserved (reads 0).
- ram_wren = wren & ~hit, purely combinational.

Read path:
- At each edge: sel_q <= hit; rdata_q <= decoded MMIO value (0 for non-existent channel or reg 3).
- q_out = sel_q ? rdata_q : ram_q.
- Load latency is 1 cycle for both regions.

Mailbox, per channel:
- Read side effects need rden & hit on that channel/reg.
- rden on DATA: valid <= 0 at that edge; returned data is pre-clear contents.
- rden on STATUS: overrun <= 0; returned status is pre-clear value.
- periph_valid with valid=0: data <= periph_data, valid <= 1.
- periph_valid with valid=1 and no same-cycle DATA read: data overwritten, valid stays 1, overrun <= 1.
- periph_valid coincident with DATA read: read returns old data; data <= new, valid stays 1, overrun unchanged (old word was consumed).
- periph_valid coincident with STATUS read: overrun set if applicable takes priority over clear.

Command, per channel:
- wren & hit on CMD: cmd <= data_in; cmd_strobe[c] = 1 for exactly the next cycle (registered).
- Back-to-back writes give back-to-back strobes.
- Writes to DATA, STATUS, reg 3 or non-existent channels are ignored; they never reach RAM.
- wren and rden in the same cycle: write takes effect, read returns pre-write value.

Reset:
- Every mailbox data/valid/overrun, cmd_out, cmd_strobe, sel_q and rdata_q go to 0, so q_out = ram_q the cycle after reset.
- Reset mid-operation discards pending mailbox data and any in-flight strobe; periph_valid during reset is ignored.

Decomposition:
- Package mmio_pkg holds:
  - register offsets REG_DATA=0, REG_STATUS=1, REG_CMD=2;
  - STATUS bit positions;
  - default MMIO_BASE;
  - channel stride of 4.
- Sub-module mmio_channel, instantiated NUM_CH times by generate. It holds mailbox data/valid/overrun, cmd register and strobe, and takes decoded rd_data/rd_status/wr_cmd enables.
- The top level does decode, read-data register and output mux.

Test Plan:
- Reset, then rden at addr 0x10 with ram_q=0xDEADBEEF -> q_out=0xDEADBEEF next cycle; ram_wren=wren at 0x10.
- periph_valid[1] pulse with data 0x12345678; load 0x1005 -> q_out=0x1 (valid); load 0x1004 -> 0x12345678; load 0x1005 -> 0x0.
- Two valid pulses on ch0 (0xA, then 0xB) without a read -> STATUS=0x3, DATA=0xB. Then a STATUS read -> next STATUS=0x1.
- DATA read of ch2 (holding 0x5) coincident with periph_valid[2] data 0x6 -> q_out=0x5; next STATUS=0x1, DATA=0x6.
- Store 0xCAFE to 0x100E (ch3 CMD) -> cmd_strobe[3]=1 for one cycle; cmd_out ch3=0xCAFE; ram_wren=0; readback 0xCAFE.
- Store to 0x1020 with NUM_CH=4 -> no state change, load returns 0. Assert reset mid-burst of strobes -> all outputs 0 next edge.
